// File: rtl/usb2_packet_rx.sv
// USB2 receive packet decoder: PID check, token/SOF/handshake/data decode, CRC5/CRC16 check.
module usb2_packet_rx #(
  parameter int unsigned MAX_DATA = 1024,
  parameter int unsigned LEN_W    = 11
) (
  input  logic             phy_clk,
  input  logic             reset_n,
  input  logic             pkt_out_act,
  input  logic [7:0]       pkt_out_byte,
  input  logic             pkt_out_latch,
  output logic             tok_valid,
  output logic [3:0]       tok_pid,
  output logic [6:0]       tok_addr,
  output logic [3:0]       tok_endp,
  output logic             sof_valid,
  output logic [10:0]      sof_frame,
  output logic             hsk_valid,
  output logic [3:0]       hsk_pid,
  output logic             data_act,
  output logic [7:0]       data_byte,
  output logic             data_latch,
  output logic             data_done,
  output logic             data_ok,
  output logic [3:0]       data_pid,
  output logic [LEN_W-1:0] data_len,
  output logic             rx_err,
  output logic [1:0]       rx_err_code
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TOKEN   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_HSK     = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_DATA);
  localparam logic [4:0]       CRC5_RES  = 5'h06;
  localparam logic [15:0]      CRC16_RES = 16'hB001;

  logic [2:0]  state, state_nxt;
  logic        byte_in_c, pid_ok_c, pid_tok_c, pid_data_c, pid_hsk_c;
  logic [3:0]  pid_q;
  logic [10:0] tok_buf;
  logic [1:0]  tok_cnt;
  logic [4:0]  crc5_q;
  logic [15:0] crc16_q;
  logic [7:0]  hold0, hold1;
  logic [1:0]  held;
  logic        over_q;
  logic        hsk_extra_q;
  logic        data_good_c;

  // Reflected CRC5 (poly 0x14) over one byte, LSB first
  function automatic logic [4:0] crc5_upd(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return r;
  endfunction

  // Reflected CRC16 (poly 0xA001) over one byte, LSB first
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Byte qualification and PID classification
  always_comb begin
    byte_in_c  = pkt_out_act & pkt_out_latch;
    pid_ok_c   = (pkt_out_byte[7:4] == ~pkt_out_byte[3:0]);
    pid_tok_c  = 1'b0;
    pid_data_c = 1'b0;
    pid_hsk_c  = 1'b0;
    case (pkt_out_byte[3:0])
      4'b0001, 4'b1001, 4'b1101, 4'b0100, 4'b0101: pid_tok_c  = 1'b1;
      4'b0011, 4'b1011, 4'b0111, 4'b1111:          pid_data_c = 1'b1;
      4'b0010, 4'b1010, 4'b1110, 4'b0110:          pid_hsk_c  = 1'b1;
      default: ;
    endcase
    data_good_c = (held == 2'd2) && !over_q;
  end

  // State register
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (byte_in_c) begin
          if (!pid_ok_c)       state_nxt = S_DISCARD;
          else if (pid_tok_c)  state_nxt = S_TOKEN;
          else if (pid_data_c) state_nxt = S_DATA;
          else if (pid_hsk_c)  state_nxt = S_HSK;
          else                 state_nxt = S_DISCARD;
        end
      end
      S_TOKEN, S_DATA, S_HSK: if (!pkt_out_act) state_nxt = S_CHECK;
      S_DISCARD:              if (!pkt_out_act) state_nxt = S_IDLE;
      S_CHECK:                state_nxt = byte_in_c ? S_DISCARD : S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Datapath, captured fields and registered result pulses
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      tok_valid <= 1'b0;  tok_pid <= '0;  tok_addr <= '0;  tok_endp <= '0;
      sof_valid <= 1'b0;  sof_frame <= '0;
      hsk_valid <= 1'b0;  hsk_pid <= '0;
      data_act <= 1'b0;   data_byte <= '0; data_latch <= 1'b0; data_done <= 1'b0;
      data_ok <= 1'b0;    data_pid <= '0;  data_len <= '0;
      rx_err <= 1'b0;     rx_err_code <= '0;
      pid_q <= '0;  tok_buf <= '0;  tok_cnt <= '0;  crc5_q <= '0;  crc16_q <= '0;
      hold0 <= '0;  hold1 <= '0;  held <= '0;  over_q <= 1'b0;  hsk_extra_q <= 1'b0;
    end else begin
      tok_valid  <= 1'b0;
      sof_valid  <= 1'b0;
      hsk_valid  <= 1'b0;
      data_latch <= 1'b0;
      data_done  <= 1'b0;
      rx_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (byte_in_c) begin
            pid_q       <= pkt_out_byte[3:0];
            tok_cnt     <= '0;
            crc5_q      <= 5'h1F;
            crc16_q     <= 16'hFFFF;
            held        <= '0;
            over_q      <= 1'b0;
            hsk_extra_q <= 1'b0;
            if (!pid_ok_c) begin
              rx_err      <= 1'b1;
              rx_err_code <= 2'd0;
            end else if (pid_data_c) begin
              data_pid <= pkt_out_byte[3:0];
              data_len <= '0;
              data_act <= 1'b1;
            end else if (!pid_tok_c && !pid_hsk_c) begin
              rx_err      <= 1'b1;
              rx_err_code <= 2'd3;
            end
          end
        end
        S_TOKEN: begin
          if (byte_in_c) begin
            if (tok_cnt == 2'd0) tok_buf[7:0]  <= pkt_out_byte;
            if (tok_cnt == 2'd1) tok_buf[10:8] <= pkt_out_byte[2:0];
            if (tok_cnt < 2'd2)  crc5_q <= crc5_upd(crc5_q, pkt_out_byte);
            if (tok_cnt != 2'd3) tok_cnt <= tok_cnt + 2'd1;
          end else if (!pkt_out_act) begin
            if (tok_cnt != 2'd2) begin
              rx_err      <= 1'b1;
              rx_err_code <= 2'd2;
            end else if (crc5_q != CRC5_RES) begin
              rx_err      <= 1'b1;
              rx_err_code <= 2'd1;
            end else if (pid_q == 4'b0101) begin
              sof_valid <= 1'b1;
              sof_frame <= tok_buf;
            end else begin
              tok_valid <= 1'b1;
              tok_pid   <= pid_q;
              tok_addr  <= tok_buf[6:0];
              tok_endp  <= tok_buf[10:7];
            end
          end
        end
        S_DATA: begin
          if (byte_in_c) begin
            crc16_q <= crc16_upd(crc16_q, pkt_out_byte);
            if (held == 2'd2) begin
              if (data_len < LEN_MAX) begin
                data_byte  <= hold0;
                data_latch <= 1'b1;
                data_len   <= data_len + LEN_W'(1);
              end else begin
                over_q <= 1'b1;
              end
              hold0 <= hold1;
              hold1 <= pkt_out_byte;
            end else begin
              if (held == 2'd0) hold0 <= pkt_out_byte;
              else              hold1 <= pkt_out_byte;
              held <= held + 2'd1;
            end
          end else if (!pkt_out_act) begin
            data_act  <= 1'b0;
            data_done <= 1'b1;
            data_ok   <= data_good_c && (crc16_q == CRC16_RES);
            if (data_good_c && (crc16_q != CRC16_RES)) begin
              rx_err      <= 1'b1;
              rx_err_code <= 2'd1;
            end
          end
        end
        S_HSK: begin
          if (byte_in_c) begin
            hsk_extra_q <= 1'b1;
          end else if (!pkt_out_act) begin
            if (hsk_extra_q) begin
              rx_err      <= 1'b1;
              rx_err_code <= 2'd2;
            end else begin
              hsk_valid <= 1'b1;
              hsk_pid   <= pid_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_packet_rx.sv
// Self-checking bench for usb2_packet_rx: directed spec vectors plus randomized packets.
module tb_usb2_packet_rx;

  localparam int unsigned MAXD = 16;
  localparam int unsigned LW   = 11;

  logic          phy_clk = 1'b0;
  logic          reset_n;
  logic          pkt_out_act;
  logic [7:0]    pkt_out_byte;
  logic          pkt_out_latch;
  logic          tok_valid;
  logic [3:0]    tok_pid;
  logic [6:0]    tok_addr;
  logic [3:0]    tok_endp;
  logic          sof_valid;
  logic [10:0]   sof_frame;
  logic          hsk_valid;
  logic [3:0]    hsk_pid;
  logic          data_act;
  logic [7:0]    data_byte;
  logic          data_latch;
  logic          data_done;
  logic          data_ok;
  logic [3:0]    data_pid;
  logic [LW-1:0] data_len;
  logic          rx_err;
  logic [1:0]    rx_err_code;

  usb2_packet_rx #(.MAX_DATA(MAXD), .LEN_W(LW)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n),
    .pkt_out_act(pkt_out_act), .pkt_out_byte(pkt_out_byte), .pkt_out_latch(pkt_out_latch),
    .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_endp(tok_endp),
    .sof_valid(sof_valid), .sof_frame(sof_frame),
    .hsk_valid(hsk_valid), .hsk_pid(hsk_pid),
    .data_act(data_act), .data_byte(data_byte), .data_latch(data_latch), .data_done(data_done),
    .data_ok(data_ok), .data_pid(data_pid), .data_len(data_len),
    .rx_err(rx_err), .rx_err_code(rx_err_code)
  );

  always #8 phy_clk = ~phy_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Event collector: counts result pulses and records emitted payload bytes
  int         c_tok = 0, c_sof = 0, c_hsk = 0, c_done = 0, c_err = 0;
  logic [1:0] c_code = 2'd0;
  logic       c_ok = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge phy_clk) begin
    if (data_latch) got_q.push_back(data_byte);
    if (tok_valid)  c_tok++;
    if (sof_valid)  c_sof++;
    if (hsk_valid)  c_hsk++;
    if (data_done) begin c_done++; c_ok = data_ok; end
    if (rx_err)    begin c_err++;  c_code = rx_err_code; end
  end

  // Current packet and reference expectations
  logic [7:0]  pkt[$];
  logic [7:0]  e_q[$];
  int          e_tok, e_sof, e_hsk, e_done, e_err;
  logic [1:0]  e_code;
  logic        e_ok;
  logic [3:0]  m_tok_pid, m_tok_endp, m_hsk_pid, m_data_pid;
  logic [6:0]  m_tok_addr;
  logic [10:0] m_sof;
  logic [10:0] m_data_len;
  logic [1:0]  m_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // USB CRC5 as transmitted: MSB-first generator x^5+x^2+1, complemented and bit-reversed
  function automatic logic [4:0] crc5_usb(input logic [10:0] d);
    logic [4:0] c;
    logic [4:0] r;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    c = ~c;
    for (int k = 0; k < 5; k++) r[k] = c[4-k];
    return r;
  endfunction

  // USB CRC16 field over pkt[first..last], generator 0x8005, complemented and bit-reversed
  function automatic logic [15:0] crc16_usb(input int first, input int last);
    logic [15:0] c;
    logic [15:0] r;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int j = first; j <= last; j++) begin
      b = pkt[j];
      for (int i = 0; i < 8; i++) begin
        fb = b[i] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    c = ~c;
    for (int k = 0; k < 16; k++) r[k] = c[15-k];
    return r;
  endfunction

  // Reference model: expected outcome of the packet held in pkt
  task automatic model_pkt();
    int          n, pl, emit;
    logic [7:0]  b0;
    logic [3:0]  p;
    logic [15:0] f;
    n = pkt.size();
    b0 = pkt[0];
    p = b0[3:0];
    e_tok = 0; e_sof = 0; e_hsk = 0; e_done = 0; e_err = 0; e_code = 2'd0; e_ok = 1'b0;
    e_q.delete();
    if (b0[7:4] !== ~b0[3:0]) begin
      e_err = 1; e_code = 2'd0;
    end else if (p inside {4'h1, 4'h9, 4'hD, 4'h4, 4'h5}) begin
      if (n != 3) begin
        e_err = 1; e_code = 2'd2;
      end else begin
        f = {pkt[2], pkt[1]};
        if (crc5_usb(f[10:0]) != f[15:11]) begin
          e_err = 1; e_code = 2'd1;
        end else if (p == 4'h5) begin
          e_sof = 1; m_sof = f[10:0];
        end else begin
          e_tok = 1; m_tok_pid = p; m_tok_addr = f[6:0]; m_tok_endp = f[10:7];
        end
      end
    end else if (p inside {4'h3, 4'hB, 4'h7, 4'hF}) begin
      e_done = 1; m_data_pid = p;
      if (n < 3) begin
        m_data_len = '0;
      end else begin
        pl = n - 3;
        emit = (pl > int'(MAXD)) ? int'(MAXD) : pl;
        for (int i = 0; i < emit; i++) e_q.push_back(pkt[1+i]);
        m_data_len = 11'(emit);
        if (pl <= int'(MAXD)) begin
          e_ok = (crc16_usb(1, n - 3) == {pkt[n-1], pkt[n-2]});
          if (!e_ok) begin e_err = 1; e_code = 2'd1; end
        end
      end
    end else if (p inside {4'h2, 4'hA, 4'hE, 4'h6}) begin
      if (n != 1) begin e_err = 1; e_code = 2'd2; end
      else begin e_hsk = 1; m_hsk_pid = p; end
    end else begin
      e_err = 1; e_code = 2'd3;
    end
    if (e_err != 0) m_code = e_code;
  endtask

  task automatic cyc(input logic a, input logic l, input logic [7:0] b);
    pkt_out_act = a; pkt_out_latch = l; pkt_out_byte = b;
    @(posedge phy_clk); #1;
  endtask

  task automatic mk_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input bit bad);
    logic [15:0] f;
    f[10:0]  = {e, a};
    f[15:11] = crc5_usb({e, a});
    if (bad) f[$urandom_range(15, 0)] ^= 1'b1;
    pkt.delete();
    pkt.push_back({~p, p});
    pkt.push_back(f[7:0]);
    pkt.push_back(f[15:8]);
  endtask

  task automatic mk_data(input logic [3:0] p, input int len, input bit seq, input bit bad);
    logic [15:0] f;
    int          idx;
    pkt.delete();
    pkt.push_back({~p, p});
    for (int i = 0; i < len; i++) pkt.push_back(seq ? 8'(i + 1) : 8'($urandom));
    f = crc16_usb(1, len);
    pkt.push_back(f[7:0]);
    pkt.push_back(f[15:8]);
    if (bad) begin
      idx = $urandom_range(pkt.size() - 1, 1);
      pkt[idx] = pkt[idx] ^ (8'h01 << $urandom_range(7, 0));
    end
  endtask

  // Drive pkt with random RX_CMD gaps, optionally a PID landing in the CHECK cycle, then compare
  task automatic run_pkt(input int gap_max, input bit ghost);
    int s_tok, s_sof, s_hsk, s_done, s_err, s_q;
    s_tok = c_tok; s_sof = c_sof; s_hsk = c_hsk; s_done = c_done; s_err = c_err;
    s_q = got_q.size();
    model_pkt();
    foreach (pkt[i]) begin
      repeat ($urandom_range(gap_max, 0)) cyc(1'b1, 1'b0, 8'($urandom));
      cyc(1'b1, 1'b1, pkt[i]);
    end
    cyc(1'b0, 1'b0, 8'h00);
    if (ghost) begin
      cyc(1'b1, 1'b1, 8'hC3);
      cyc(1'b1, 1'b1, 8'h00);
      cyc(1'b1, 1'b1, 8'h00);
    end
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    check("tok_valid_pulses", 32'(c_tok - s_tok), 32'(e_tok));
    check("sof_valid_pulses", 32'(c_sof - s_sof), 32'(e_sof));
    check("hsk_valid_pulses", 32'(c_hsk - s_hsk), 32'(e_hsk));
    check("data_done_pulses", 32'(c_done - s_done), 32'(e_done));
    check("rx_err_pulses", 32'(c_err - s_err), 32'(e_err));
    if (e_err != 0)  check("rx_err_code_at_pulse", 32'(c_code), 32'(e_code));
    if (e_done != 0) check("data_ok", 32'(c_ok), 32'(e_ok));
    check("emitted_count", 32'(got_q.size() - s_q), 32'(e_q.size()));
    if (got_q.size() - s_q == e_q.size())
      foreach (e_q[i]) check("emitted_byte", 32'(got_q[s_q+i]), 32'(e_q[i]));
    check("tok_pid", 32'(tok_pid), 32'(m_tok_pid));
    check("tok_addr", 32'(tok_addr), 32'(m_tok_addr));
    check("tok_endp", 32'(tok_endp), 32'(m_tok_endp));
    check("sof_frame", 32'(sof_frame), 32'(m_sof));
    check("hsk_pid", 32'(hsk_pid), 32'(m_hsk_pid));
    check("data_pid", 32'(data_pid), 32'(m_data_pid));
    check("data_len", 32'(data_len), 32'(m_data_len));
    check("rx_err_code_held", 32'(rx_err_code), 32'(m_code));
    check("data_act_idle", 32'(data_act), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({tok_valid, sof_valid, hsk_valid, data_act, data_latch,
                               data_done, data_ok, rx_err}), 32'd0);
    check({tag, "_tok"}, 32'({tok_pid, tok_addr, tok_endp}), 32'd0);
    check({tag, "_sof_hsk"}, 32'({sof_frame, hsk_pid}), 32'd0);
    check({tag, "_data"}, 32'({data_byte, data_pid, data_len, rx_err_code}), 32'd0);
  endtask

  task automatic model_reset();
    m_tok_pid = '0; m_tok_addr = '0; m_tok_endp = '0; m_sof = '0;
    m_hsk_pid = '0; m_data_pid = '0; m_data_len = '0; m_code = '0;
  endtask

  logic [3:0] tok_pids[4]  = '{4'h1, 4'h9, 4'hD, 4'h4};
  logic [3:0] data_pids[4] = '{4'h3, 4'hB, 4'h7, 4'hF};
  logic [3:0] hsk_pids[4]  = '{4'h2, 4'hA, 4'hE, 4'h6};
  logic [7:0] unsup[3]     = '{8'hF0, 8'h78, 8'h3C};

  initial begin
    logic [7:0]  b;
    logic [10:0] fr;
    int          kind;
    reset_n = 1'b0;
    pkt_out_act = 1'b0; pkt_out_latch = 1'b0; pkt_out_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge phy_clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);

    // Directed vectors
    pkt = '{8'h2D, 8'h00, 8'h10};             run_pkt(0, 1'b0);
    pkt = '{8'h2D, 8'h00, 8'h11};             run_pkt(0, 1'b0);
    pkt = '{8'hC3, 8'h00, 8'h00};             run_pkt(0, 1'b0);
    mk_data(4'hB, 8, 1'b1, 1'b0);             run_pkt(0, 1'b0);
    pkt = '{8'h2C};                           run_pkt(0, 1'b0);
    pkt = '{8'hD2};                           run_pkt(0, 1'b0);
    pkt = '{8'hD2, 8'h00};                    run_pkt(0, 1'b0);
    pkt = '{8'h69, 8'h00};                    run_pkt(1, 1'b0);
    pkt = '{8'hF0};                           run_pkt(0, 1'b0);
    pkt = '{8'hC3};                           run_pkt(0, 1'b0);
    pkt = '{8'hC3, 8'h55};                    run_pkt(0, 1'b0);
    mk_data(4'h3, int'(MAXD), 1'b0, 1'b0);     run_pkt(1, 1'b0);
    mk_data(4'h7, int'(MAXD) + 1, 1'b0, 1'b0); run_pkt(1, 1'b0);
    mk_data(4'hF, 5, 1'b0, 1'b1);             run_pkt(0, 1'b0);
    mk_token(4'h5, 7'h2A, 4'h9, 1'b0);        run_pkt(2, 1'b0);
    mk_token(4'h1, 7'h11, 4'h3, 1'b0);        run_pkt(0, 1'b1);

    // Async reset mid-DATA1, then a clean IN token
    cyc(1'b1, 1'b1, 8'h4B);
    cyc(1'b1, 1'b1, 8'h01);
    cyc(1'b1, 1'b1, 8'h02);
    cyc(1'b1, 1'b1, 8'h03);
    check("data_act_mid_packet", 32'(data_act), 32'd1);
    #3 reset_n = 1'b0;
    pkt_out_act = 1'b0; pkt_out_latch = 1'b0;
    #2;
    check_all_zero("midreset");
    model_reset();
    cyc(1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    pkt = '{8'h69, 8'h00, 8'h10};             run_pkt(0, 1'b0);

    // Randomized packets
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(7, 0);
      case (kind)
        0: mk_token(tok_pids[$urandom_range(3, 0)], 7'($urandom), 4'($urandom),
                    $urandom_range(3, 0) == 0);
        1: begin
             fr = 11'($urandom);
             mk_token(4'h5, fr[6:0], fr[10:7], $urandom_range(3, 0) == 0);
           end
        2: mk_data(data_pids[$urandom_range(3, 0)], $urandom_range(int'(MAXD) + 4, 0), 1'b0,
                   $urandom_range(3, 0) == 0);
        3: begin
             pkt.delete();
             b = {~hsk_pids[$urandom_range(3, 0)], hsk_pids[$urandom_range(3, 0)]};
             b[7:4] = ~b[3:0];
             pkt.push_back(b);
             if ($urandom_range(3, 0) == 0) pkt.push_back(8'($urandom));
           end
        4: begin
             b = 8'($urandom);
             if (b[7:4] == ~b[3:0]) b[7] = ~b[7];
             pkt.delete();
             pkt.push_back(b);
             pkt.push_back(8'($urandom));
           end
        5: begin
             pkt.delete();
             pkt.push_back(unsup[$urandom_range(2, 0)]);
           end
        6: begin
             mk_token(tok_pids[$urandom_range(3, 0)], 7'($urandom), 4'($urandom), 1'b0);
             if ($urandom_range(1, 0) == 0) void'(pkt.pop_back());
             else pkt.push_back(8'($urandom));
           end
        default: begin
             pkt.delete();
             pkt.push_back(8'hC3);
             if ($urandom_range(1, 0) == 0) pkt.push_back(8'($urandom));
           end
      endcase
      run_pkt($urandom_range(2, 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
